// File: rtl/proc_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : proc_run_ctrl                                                   |
// | Brief  : Bring-up run controller for the processor core. It holds the    |
// |          core in reset, lets it settle, then clock-enables it. While it   |
// |          runs it counts cycles and writebacks and folds the writeback     |
// |          data into a rotate-xor signature. The run ends on halt (PC       |
// |          stalled), budget timeout or abort, and results are held.         |
// | Ports  : p_clk/p_rst       clock, synchronous active-low reset            |
// |          i_start/i_abort   run control pulses                             |
// |          i_max_cycles      RUN-cycle budget (0 = unlimited)               |
// |          i_pc, i_wb_*      observed core PC and writeback bus             |
// |          o_core_rst_n/ce   core reset and clock-enable                    |
// |          o_busy/o_done     run phase flags                                |
// |          o_status          00 none, 01 halt, 10 timeout, 11 abort         |
// |          o_cycles/o_wb_count/o_signature  run results                     |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module proc_run_ctrl #(
  parameter int PC_WIDTH      = 32,
  parameter int DWIDTH        = 32,
  parameter int RST_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int HALT_CYCLES   = 4,
  parameter int CNT_WIDTH     = 16,
  parameter int SIG_WIDTH     = 32
) (
  input  logic                 p_clk,
  input  logic                 p_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [CNT_WIDTH-1:0] i_max_cycles,
  input  logic [PC_WIDTH-1:0]  i_pc,
  input  logic                 i_wb_valid,
  input  logic [DWIDTH-1:0]    i_wb_data,
  output logic                 o_core_rst_n,
  output logic                 o_core_ce,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [1:0]           o_status,
  output logic [CNT_WIDTH-1:0] o_cycles,
  output logic [CNT_WIDTH-1:0] o_wb_count,
  output logic [SIG_WIDTH-1:0] o_signature
);

  localparam int c_PH_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int c_PH_W   = $clog2(c_PH_MAX + 1);
  localparam int c_HM_W   = $clog2(HALT_CYCLES + 1);

  localparam logic [1:0] c_ST_NONE    = 2'b00;
  localparam logic [1:0] c_ST_HALT    = 2'b01;
  localparam logic [1:0] c_ST_TIMEOUT = 2'b10;
  localparam logic [1:0] c_ST_ABORT   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               r_state;
  logic [c_PH_W-1:0]    r_ph;
  logic [c_HM_W-1:0]    r_match;
  logic                 r_pc_valid;
  logic [PC_WIDTH-1:0]  r_prev_pc;
  logic [CNT_WIDTH-1:0] r_max;
  logic [CNT_WIDTH-1:0] r_cycles;
  logic [CNT_WIDTH-1:0] r_wb_count;
  logic [SIG_WIDTH-1:0] r_sig;
  logic [1:0]           r_status;
  logic                 r_core_rst_n;
  logic                 r_core_ce;
  logic                 r_busy;
  logic                 r_done;

  logic [SIG_WIDTH-1:0] w_wb_ext;
  logic                 w_cyc_sat;
  logic [CNT_WIDTH-1:0] w_cyc_inc;
  logic [CNT_WIDTH-1:0] w_wbc_inc;
  logic [SIG_WIDTH-1:0] w_sig_next;
  logic                 w_pc_same;
  logic                 w_halt;
  logic                 w_timeout;

  generate
    if (DWIDTH >= SIG_WIDTH) begin : g_wb_trunc
      assign w_wb_ext = i_wb_data[SIG_WIDTH-1:0];
    end else begin : g_wb_zext
      assign w_wb_ext = {{(SIG_WIDTH-DWIDTH){1'b0}}, i_wb_data};
    end
  endgenerate

  // Saturating increments: an all-ones counter stays put.
  assign w_cyc_sat  = &r_cycles;
  assign w_cyc_inc  = w_cyc_sat ? r_cycles : r_cycles + 1'b1;
  assign w_wbc_inc  = (&r_wb_count) ? r_wb_count : r_wb_count + 1'b1;
  assign w_sig_next = {r_sig[SIG_WIDTH-2:0], r_sig[SIG_WIDTH-1]} ^ w_wb_ext;

  // The very first RUN cycle has no previous PC, so r_pc_valid gates the compare.
  assign w_pc_same = r_pc_valid && (i_pc == r_prev_pc);
  assign w_halt    = w_pc_same && (r_match == c_HM_W'(HALT_CYCLES - 1));
  // A saturated cycle counter is not a fresh arrival at the budget.
  assign w_timeout = (r_max != '0) && !w_cyc_sat && (w_cyc_inc == r_max);

  always_ff @(posedge p_clk) begin
    if (!p_rst) begin
      r_state      <= S_IDLE;
      r_ph         <= '0;
      r_match      <= '0;
      r_pc_valid   <= 1'b0;
      r_prev_pc    <= '0;
      r_max        <= '0;
      r_cycles     <= '0;
      r_wb_count   <= '0;
      r_sig        <= '0;
      r_status     <= c_ST_NONE;
      r_core_rst_n <= 1'b0;
      r_core_ce    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state      <= S_RESET;
            r_ph         <= '0;
            r_match      <= '0;
            r_pc_valid   <= 1'b0;
            r_max        <= i_max_cycles;
            r_cycles     <= '0;
            r_wb_count   <= '0;
            r_sig        <= '0;
            r_status     <= c_ST_NONE;
            r_core_rst_n <= 1'b0;
            r_core_ce    <= 1'b0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
          end
        end

        S_RESET: begin
          if (i_abort) begin
            r_state      <= S_DONE;
            r_status     <= c_ST_ABORT;
            r_core_rst_n <= 1'b1;
            r_core_ce    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
          end else if (r_ph == c_PH_W'(RST_CYCLES - 1)) begin
            r_state      <= S_SETTLE;
            r_ph         <= '0;
            r_core_rst_n <= 1'b1;
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end

        S_SETTLE: begin
          if (i_abort) begin
            r_state      <= S_DONE;
            r_status     <= c_ST_ABORT;
            r_core_ce    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
          end else if (r_ph == c_PH_W'(SETTLE_CYCLES - 1)) begin
            r_state   <= S_RUN;
            r_ph      <= '0;
            r_core_ce <= 1'b1;
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end

        S_RUN: begin
          if (i_abort) begin
            // Abort freezes results as they stood before this cycle.
            r_state   <= S_DONE;
            r_status  <= c_ST_ABORT;
            r_core_ce <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_cycles   <= w_cyc_inc;
            r_prev_pc  <= i_pc;
            r_pc_valid <= 1'b1;
            r_match    <= w_pc_same ? r_match + 1'b1 : '0;
            if (i_wb_valid) begin
              r_wb_count <= w_wbc_inc;
              r_sig      <= w_sig_next;
            end
            if (w_halt || w_timeout) begin
              r_state   <= S_DONE;
              r_status  <= w_halt ? c_ST_HALT : c_ST_TIMEOUT;
              r_core_ce <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
            end
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_core_rst_n <= 1'b0;
          r_core_ce    <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
        end
      endcase
    end
  end

  assign o_core_rst_n = r_core_rst_n;
  assign o_core_ce    = r_core_ce;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_status     = r_status;
  assign o_cycles     = r_cycles;
  assign o_wb_count   = r_wb_count;
  assign o_signature  = r_sig;

endmodule
`default_nettype wire
